// File: rtl/uc_coordena_asteroides_tiros.sv
// Moore control unit sequencing one game tick: sweep all shot slots, then all asteroid slots, then pulse done.
// UC_COORDENA_DB_ESTADO_EN: when defined, db_estado_coordena_asteroides_tiros shows the state code, else it reads 0.
module uc_coordena_asteroides_tiros (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_tiro_e_asteroides,
  input  logic       rco_contador_tiro,
  input  logic       rco_contador_asteroides,
  input  logic       fim_comparacao_tiros_e_asteroides,
  input  logic       fim_move_tiros,
  input  logic       fim_comparacao_asteroides_com_a_nave_e_tiros,
  input  logic       fim_move_asteroides,
  output logic       movimenta_tiro,
  output logic       sinal_movimenta_asteroides,
  output logic       sinal_compara_tiros_e_asteroides,
  output logic       sinal_compara_asteroides_com_a_nave_e_tiro,
  output logic       conta_contador_tiro,
  output logic       reset_contador_tiro,
  output logic       conta_contador_asteroides,
  output logic       reset_contador_asteroides,
  output logic       fim_move_tiro_e_asteroides,
  output logic [4:0] db_estado_coordena_asteroides_tiros
);

  typedef enum logic [4:0] {
    INICIAL       = 5'h00,
    ZERA_TIRO     = 5'h01,
    COMPARA_TIRO  = 5'h02,
    MOVE_TIRO     = 5'h03,
    VERIFICA_TIRO = 5'h04,
    CONTA_TIRO    = 5'h05,
    ZERA_AST      = 5'h06,
    COMPARA_AST   = 5'h07,
    MOVE_AST      = 5'h08,
    VERIFICA_AST  = 5'h09,
    CONTA_AST     = 5'h0A,
    FIM           = 5'h0B
  } state_t;

  state_t state, next_state;

  always_ff @(posedge clock) begin
    if (reset) state <= INICIAL;
    else       state <= next_state;
  end

  always_comb begin
    next_state = INICIAL;
    case (state)
      INICIAL:       next_state = move_tiro_e_asteroides ? ZERA_TIRO : INICIAL;
      ZERA_TIRO:     next_state = COMPARA_TIRO;
      COMPARA_TIRO:  next_state = fim_comparacao_tiros_e_asteroides ? MOVE_TIRO : COMPARA_TIRO;
      MOVE_TIRO:     next_state = fim_move_tiros ? VERIFICA_TIRO : MOVE_TIRO;
      VERIFICA_TIRO: next_state = rco_contador_tiro ? ZERA_AST : CONTA_TIRO;
      CONTA_TIRO:    next_state = COMPARA_TIRO;
      ZERA_AST:      next_state = COMPARA_AST;
      COMPARA_AST:   next_state = fim_comparacao_asteroides_com_a_nave_e_tiros ? MOVE_AST : COMPARA_AST;
      MOVE_AST:      next_state = fim_move_asteroides ? VERIFICA_AST : MOVE_AST;
      VERIFICA_AST:  next_state = rco_contador_asteroides ? FIM : CONTA_AST;
      CONTA_AST:     next_state = COMPARA_AST;
      FIM:           next_state = INICIAL;
      // Unused codes fall back to idle.
      default:       next_state = INICIAL;
    endcase
  end

  always_comb begin
    movimenta_tiro                             = 1'b0;
    sinal_movimenta_asteroides                 = 1'b0;
    sinal_compara_tiros_e_asteroides           = 1'b0;
    sinal_compara_asteroides_com_a_nave_e_tiro = 1'b0;
    conta_contador_tiro                        = 1'b0;
    reset_contador_tiro                        = 1'b0;
    conta_contador_asteroides                  = 1'b0;
    reset_contador_asteroides                  = 1'b0;
    fim_move_tiro_e_asteroides                 = 1'b0;
    case (state)
      ZERA_TIRO:    reset_contador_tiro                        = 1'b1;
      COMPARA_TIRO: sinal_compara_tiros_e_asteroides           = 1'b1;
      MOVE_TIRO:    movimenta_tiro                             = 1'b1;
      CONTA_TIRO:   conta_contador_tiro                        = 1'b1;
      ZERA_AST:     reset_contador_asteroides                  = 1'b1;
      COMPARA_AST:  sinal_compara_asteroides_com_a_nave_e_tiro = 1'b1;
      MOVE_AST:     sinal_movimenta_asteroides                 = 1'b1;
      CONTA_AST:    conta_contador_asteroides                  = 1'b1;
      FIM:          fim_move_tiro_e_asteroides                 = 1'b1;
      default:      ;
    endcase
  end

`ifdef UC_COORDENA_DB_ESTADO_EN
  assign db_estado_coordena_asteroides_tiros = state;
`else
  assign db_estado_coordena_asteroides_tiros = 5'b00000;
`endif

endmodule

// File: tb/tb_uc_coordena_asteroides_tiros.sv
// Directed bench for uc_coordena_asteroides_tiros: each step queues the expected output vector, then compares after the edge.
module tb_uc_coordena_asteroides_tiros;

  logic       clock = 1'b0;
  logic       reset;
  logic       move_tiro_e_asteroides;
  logic       rco_contador_tiro;
  logic       rco_contador_asteroides;
  logic       fim_comparacao_tiros_e_asteroides;
  logic       fim_move_tiros;
  logic       fim_comparacao_asteroides_com_a_nave_e_tiros;
  logic       fim_move_asteroides;
  logic       movimenta_tiro;
  logic       sinal_movimenta_asteroides;
  logic       sinal_compara_tiros_e_asteroides;
  logic       sinal_compara_asteroides_com_a_nave_e_tiro;
  logic       conta_contador_tiro;
  logic       reset_contador_tiro;
  logic       conta_contador_asteroides;
  logic       reset_contador_asteroides;
  logic       fim_move_tiro_e_asteroides;
  logic [4:0] db_estado_coordena_asteroides_tiros;

  // Clock / reset
  always #5 clock = ~clock;

  uc_coordena_asteroides_tiros dut (
    .clock                                        (clock),
    .reset                                        (reset),
    .move_tiro_e_asteroides                       (move_tiro_e_asteroides),
    .rco_contador_tiro                            (rco_contador_tiro),
    .rco_contador_asteroides                      (rco_contador_asteroides),
    .fim_comparacao_tiros_e_asteroides            (fim_comparacao_tiros_e_asteroides),
    .fim_move_tiros                               (fim_move_tiros),
    .fim_comparacao_asteroides_com_a_nave_e_tiros (fim_comparacao_asteroides_com_a_nave_e_tiros),
    .fim_move_asteroides                          (fim_move_asteroides),
    .movimenta_tiro                               (movimenta_tiro),
    .sinal_movimenta_asteroides                   (sinal_movimenta_asteroides),
    .sinal_compara_tiros_e_asteroides             (sinal_compara_tiros_e_asteroides),
    .sinal_compara_asteroides_com_a_nave_e_tiro   (sinal_compara_asteroides_com_a_nave_e_tiro),
    .conta_contador_tiro                          (conta_contador_tiro),
    .reset_contador_tiro                          (reset_contador_tiro),
    .conta_contador_asteroides                    (conta_contador_asteroides),
    .reset_contador_asteroides                    (reset_contador_asteroides),
    .fim_move_tiro_e_asteroides                   (fim_move_tiro_e_asteroides),
    .db_estado_coordena_asteroides_tiros          (db_estado_coordena_asteroides_tiros)
  );

  // Vector: {db[4:0], fim, rst_ast, conta_ast, rst_tiro, conta_tiro, cmp_ast, cmp_tiro, mov_ast, mov_tiro}
  localparam int W = 14;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Expected outputs for a given state code, straight from the state table.
  function automatic logic [W-1:0] model_vec(input logic [4:0] code);
    logic [8:0] cmd;
    logic [4:0] db;
    cmd = 9'b0;
    case (code)
      5'h01: cmd = 9'b0_0_0_1_0_0_0_0_0;
      5'h02: cmd = 9'b0_0_0_0_0_0_1_0_0;
      5'h03: cmd = 9'b0_0_0_0_0_0_0_0_1;
      5'h05: cmd = 9'b0_0_0_0_1_0_0_0_0;
      5'h06: cmd = 9'b0_1_0_0_0_0_0_0_0;
      5'h07: cmd = 9'b0_0_0_0_0_1_0_0_0;
      5'h08: cmd = 9'b0_0_0_0_0_0_0_1_0;
      5'h0A: cmd = 9'b0_0_1_0_0_0_0_0_0;
      5'h0B: cmd = 9'b1_0_0_0_0_0_0_0_0;
      default: cmd = 9'b0;
    endcase
`ifdef UC_COORDENA_DB_ESTADO_EN
    db = code;
`else
    db = 5'b00000;
`endif
    return {db, cmd};
  endfunction

  function automatic logic [W-1:0] observed();
    return {db_estado_coordena_asteroides_tiros,
            fim_move_tiro_e_asteroides,
            reset_contador_asteroides,
            conta_contador_asteroides,
            reset_contador_tiro,
            conta_contador_tiro,
            sinal_compara_asteroides_com_a_nave_e_tiro,
            sinal_compara_tiros_e_asteroides,
            sinal_movimenta_asteroides,
            movimenta_tiro};
  endfunction

  // Driver: inputs already set; queue the expected state after the next edge, clock it, compare.
  task automatic step(input logic [4:0] exp_code, input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    exp_q.push_back(model_vec(exp_code));
    @(posedge clock);
    #1;
    exp_v = exp_q.pop_front();
    got_v = observed();
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (state %h)", tag, got_v, exp_v, exp_code);
    end
  endtask

  task automatic set_done(input logic v);
    fim_comparacao_tiros_e_asteroides            = v;
    fim_move_tiros                               = v;
    fim_comparacao_asteroides_com_a_nave_e_tiros = v;
    fim_move_asteroides                          = v;
  endtask

  initial begin
    reset = 1'b1;
    move_tiro_e_asteroides  = 1'b0;
    rco_contador_tiro       = 1'b0;
    rco_contador_asteroides = 1'b0;
    set_done(1'b0);
    @(posedge clock);
    #1;

    // Reset and idle
    step(5'h00, "reset_1");
    step(5'h00, "reset_2");
    reset = 1'b0;
    step(5'h00, "idle_1");
    step(5'h00, "idle_2");

    // Sweep 1: single shot slot, single asteroid slot, done inputs driven one at a time
    move_tiro_e_asteroides = 1'b1;
    step(5'h01, "zera_tiro");
    move_tiro_e_asteroides = 1'b0;
    step(5'h02, "compara_tiro");
    step(5'h02, "compara_tiro_hold1");
    step(5'h02, "compara_tiro_hold2");
    fim_comparacao_tiros_e_asteroides = 1'b1;
    step(5'h03, "move_tiro");
    fim_comparacao_tiros_e_asteroides = 1'b0;
    step(5'h03, "move_tiro_hold");
    fim_move_tiros    = 1'b1;
    rco_contador_tiro = 1'b1;
    step(5'h04, "verifica_tiro");
    fim_move_tiros = 1'b0;
    step(5'h06, "zera_ast");
    step(5'h07, "compara_ast");
    step(5'h07, "compara_ast_hold");
    fim_comparacao_asteroides_com_a_nave_e_tiros = 1'b1;
    step(5'h08, "move_ast");
    fim_comparacao_asteroides_com_a_nave_e_tiros = 1'b0;
    step(5'h08, "move_ast_hold");
    fim_move_asteroides     = 1'b1;
    rco_contador_asteroides = 1'b1;
    step(5'h09, "verifica_ast");
    fim_move_asteroides = 1'b0;
    step(5'h0B, "fim_pulse");
    step(5'h00, "fim_to_idle");
    step(5'h00, "idle_after_fim");

    // Sweep 2: all done inputs high, three shot slots, two asteroid slots, start held
    set_done(1'b1);
    rco_contador_tiro       = 1'b0;
    rco_contador_asteroides = 1'b0;
    move_tiro_e_asteroides  = 1'b1;
    step(5'h01, "s2_zera_tiro");
    for (int loop = 0; loop < 2; loop++) begin
      step(5'h02, "s2_compara_tiro");
      step(5'h03, "s2_move_tiro");
      step(5'h04, "s2_verifica_tiro");
      step(5'h05, "s2_conta_tiro");
    end
    step(5'h02, "s2_compara_tiro_last");
    step(5'h03, "s2_move_tiro_last");
    step(5'h04, "s2_verifica_tiro_last");
    rco_contador_tiro = 1'b1;
    step(5'h06, "s2_zera_ast");
    step(5'h07, "s2_compara_ast");
    step(5'h08, "s2_move_ast");
    step(5'h09, "s2_verifica_ast");
    step(5'h0A, "s2_conta_ast");
    step(5'h07, "s2_compara_ast_last");
    step(5'h08, "s2_move_ast_last");
    rco_contador_asteroides = 1'b1;
    step(5'h09, "s2_verifica_ast_last");
    step(5'h0B, "s2_fim");
    step(5'h00, "s2_idle");
    step(5'h01, "s3_restart");

    // Sweep 3: reset while waiting in MOVE_AST
    move_tiro_e_asteroides = 1'b0;
    step(5'h02, "s3_compara_tiro");
    step(5'h03, "s3_move_tiro");
    step(5'h04, "s3_verifica_tiro");
    step(5'h06, "s3_zera_ast");
    step(5'h07, "s3_compara_ast");
    fim_move_asteroides = 1'b0;
    step(5'h08, "s3_move_ast");
    step(5'h08, "s3_move_ast_hold");
    reset = 1'b1;
    step(5'h00, "s3_reset_mid_sweep");
    reset = 1'b0;
    set_done(1'b0);
    step(5'h00, "s3_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
